// File: rtl/csr_commit_unit_if.sv
// Retire-stage CSR commit bundle: the commit stage drives it, csr_commit_unit consumes it.
interface csr_commit_unit_if #(
   parameter int XLEN = 64
);
   logic            commit_valid_i;
   logic [XLEN-1:0] commit_csrdata_i;
   logic [11:0]     commit_csrindex_i;
   logic            commit_csren_i;
   logic            commit_mret_i;
   logic            commit_sret_i;
   logic [4:0]      commit_fflag_i;
   logic            commit_fflagen_i;

   modport master (
      output commit_valid_i, commit_csrdata_i, commit_csrindex_i, commit_csren_i,
             commit_mret_i, commit_sret_i, commit_fflag_i, commit_fflagen_i
   );
   modport slave (
      input  commit_valid_i, commit_csrdata_i, commit_csrindex_i, commit_csren_i,
             commit_mret_i, commit_sret_i, commit_fflag_i, commit_fflagen_i
   );
endinterface

// File: rtl/csr_commit_unit.sv
// CSR commit unit: holds privilege, mstatus/sstatus fields, fcsr, mepc/sepc and applies
// one retire-stage commit per cycle; mret/sret produce a registered redirect pulse.
module csr_commit_unit #(
   parameter int XLEN      = 64,
   parameter bit HAS_UMODE = 1'b1
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   csr_commit_unit_if.slave commit,
   output logic [1:0]      priv_o,
   output logic [XLEN-1:0] mstatus_o,
   output logic [7:0]      fcsr_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] sepc_o,
   output logic            xret_valid_o,
   output logic [XLEN-1:0] xret_pc_o,
   output logic            conflict_o
);
   localparam logic [1:0] PRV_M  = 2'b11;
   localparam logic [1:0] XPP_CLR = HAS_UMODE ? 2'b00 : 2'b11;

   logic [1:0]      r_priv, w_priv;
   logic            r_mie, r_sie, r_mpie, r_spie, r_spp;
   logic            w_mie, w_sie, w_mpie, w_spie, w_spp;
   logic [1:0]      r_mpp, w_mpp;
   logic [2:0]      r_frm, w_frm;
   logic [4:0]      r_fflags, w_fflags;
   logic [XLEN-1:0] r_mepc, r_sepc, r_xret_pc;
   logic [XLEN-1:0] w_mepc, w_sepc, w_xret_pc;
   logic            r_xret_valid, r_conflict;
   logic            w_mret, w_sret, w_wr, w_conflict;
   logic [XLEN-1:0] w_d;

   // mret wins over sret; any xret drops a same-cycle CSR write
   assign w_d        = commit.commit_csrdata_i;
   assign w_mret     = commit.commit_valid_i & commit.commit_mret_i;
   assign w_sret     = commit.commit_valid_i & commit.commit_sret_i & ~commit.commit_mret_i;
   assign w_wr       = commit.commit_valid_i & commit.commit_csren_i
                       & ~(commit.commit_mret_i | commit.commit_sret_i);
   assign w_conflict = commit.commit_valid_i
                       & ((commit.commit_mret_i & commit.commit_sret_i)
                          | (commit.commit_csren_i & (commit.commit_mret_i | commit.commit_sret_i)));

   // Next architectural state: CSR write, then xret, then fflag accrual on top of the written base
   always_comb begin
      w_priv    = r_priv;
      w_mie     = r_mie;
      w_sie     = r_sie;
      w_mpie    = r_mpie;
      w_spie    = r_spie;
      w_spp     = r_spp;
      w_mpp     = r_mpp;
      w_frm     = r_frm;
      w_fflags  = r_fflags;
      w_mepc    = r_mepc;
      w_sepc    = r_sepc;
      w_xret_pc = r_xret_pc;
      if (w_wr) begin
         case (commit.commit_csrindex_i)
            12'h001: w_fflags = w_d[4:0];
            12'h002: w_frm    = w_d[2:0];
            12'h003: {w_frm, w_fflags} = w_d[7:0];
            12'h300: begin
               w_mie  = w_d[3];
               w_sie  = w_d[1];
               w_mpie = w_d[7];
               w_spie = w_d[5];
               w_spp  = w_d[8];
               // 2'b10 is reserved: keep the old MPP; without U-mode MPP is stuck at M
               if (!HAS_UMODE)              w_mpp = PRV_M;
               else if (w_d[12:11] != 2'b10) w_mpp = w_d[12:11];
            end
            12'h100: begin
               w_sie  = w_d[1];
               w_spie = w_d[5];
               w_spp  = w_d[8];
            end
            12'h341: w_mepc = {w_d[XLEN-1:2], 2'b00};
            12'h141: w_sepc = {w_d[XLEN-1:2], 2'b00};
            default: ;
         endcase
      end
      if (w_mret) begin
         w_priv    = r_mpp;
         w_mie     = r_mpie;
         w_mpie    = 1'b1;
         w_mpp     = XPP_CLR;
         w_xret_pc = r_mepc;
      end else if (w_sret) begin
         w_priv    = {1'b0, r_spp};
         w_sie     = r_spie;
         w_spie    = 1'b1;
         w_spp     = 1'b0;
         w_xret_pc = r_sepc;
      end
      if (commit.commit_valid_i && commit.commit_fflagen_i)
         w_fflags = w_fflags | commit.commit_fflag_i;
   end

   // State and output registers; pulses drop whenever they are not re-triggered
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_priv       <= PRV_M;
         r_mie        <= 1'b0;
         r_sie        <= 1'b0;
         r_mpie       <= 1'b0;
         r_spie       <= 1'b0;
         r_spp        <= 1'b0;
         r_mpp        <= PRV_M;
         r_frm        <= '0;
         r_fflags     <= '0;
         r_mepc       <= '0;
         r_sepc       <= '0;
         r_xret_pc    <= '0;
         r_xret_valid <= 1'b0;
         r_conflict   <= 1'b0;
      end else begin
         r_priv       <= w_priv;
         r_mie        <= w_mie;
         r_sie        <= w_sie;
         r_mpie       <= w_mpie;
         r_spie       <= w_spie;
         r_spp        <= w_spp;
         r_mpp        <= w_mpp;
         r_frm        <= w_frm;
         r_fflags     <= w_fflags;
         r_mepc       <= w_mepc;
         r_sepc       <= w_sepc;
         r_xret_pc    <= w_xret_pc;
         r_xret_valid <= w_mret | w_sret;
         r_conflict   <= w_conflict;
      end
   end

   // mstatus view; FS is hard-wired dirty
   always_comb begin
      mstatus_o        = '0;
      mstatus_o[1]     = r_sie;
      mstatus_o[3]     = r_mie;
      mstatus_o[5]     = r_spie;
      mstatus_o[7]     = r_mpie;
      mstatus_o[8]     = r_spp;
      mstatus_o[12:11] = r_mpp;
      mstatus_o[14:13] = 2'b11;
   end

   assign priv_o       = r_priv;
   assign fcsr_o       = {r_frm, r_fflags};
   assign mepc_o       = r_mepc;
   assign sepc_o       = r_sepc;
   assign xret_valid_o = r_xret_valid;
   assign xret_pc_o    = r_xret_pc;
   assign conflict_o   = r_conflict;
endmodule

// File: tb/tb_csr_commit_unit.sv
// Bench for csr_commit_unit: directed scenarios plus random commits against a word-level model.
module tb_csr_commit_unit;
   localparam int XLEN = 64;
   localparam logic [63:0] MMASK = 64'h19AA;  // MPP, SPP, MPIE, SPIE, MIE, SIE
   localparam logic [63:0] SMASK = 64'h0122;  // SPP, SPIE, SIE

   logic            clk_i = 1'b0;
   logic            arst_ni = 1'b0;
   logic [1:0]      priv_o;
   logic [XLEN-1:0] mstatus_o, mepc_o, sepc_o, xret_pc_o;
   logic [7:0]      fcsr_o;
   logic            xret_valid_o, conflict_o;

   csr_commit_unit_if #(.XLEN(XLEN)) cif ();

   csr_commit_unit #(.XLEN(XLEN), .HAS_UMODE(1'b1)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .commit(cif.slave),
      .priv_o(priv_o), .mstatus_o(mstatus_o), .fcsr_o(fcsr_o),
      .mepc_o(mepc_o), .sepc_o(sepc_o), .xret_valid_o(xret_valid_o),
      .xret_pc_o(xret_pc_o), .conflict_o(conflict_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: mstatus kept as a raw word, FS added at the view
   logic [1:0]  m_priv;
   logic [63:0] m_ms, m_mepc, m_sepc, m_xpc;
   logic [2:0]  m_frm;
   logic [4:0]  m_ff;
   logic        m_xv, m_cf;

   function automatic void m_reset();
      m_priv = 2'd3; m_ms = 64'h1800; m_mepc = '0; m_sepc = '0; m_xpc = '0;
      m_frm = '0; m_ff = '0; m_xv = 1'b0; m_cf = 1'b0;
   endfunction

   function automatic void m_step(input logic v, input logic [63:0] d, input logic [11:0] idx,
                                  input logic en, input logic mr, input logic sr,
                                  input logic [4:0] ff, input logic ffen);
      logic [1:0] old_mpp;
      logic [1:0] new_mpp;
      m_xv = 1'b0;
      m_cf = 1'b0;
      if (!v) return;
      m_cf = (mr && sr) || (en && (mr || sr));
      if (en && !mr && !sr) begin
         case (idx)
            12'h001: m_ff = d[4:0];
            12'h002: m_frm = d[2:0];
            12'h003: begin m_ff = d[4:0]; m_frm = d[7:5]; end
            12'h300: begin
               old_mpp = m_ms[12:11];
               new_mpp = d[12:11];
               m_ms = (m_ms & ~MMASK) | (d & MMASK);
               if (new_mpp == 2'b10) m_ms[12:11] = old_mpp;
            end
            12'h100: m_ms = (m_ms & ~SMASK) | (d & SMASK);
            12'h341: m_mepc = d & ~64'h3;
            12'h141: m_sepc = d & ~64'h3;
            default: ;
         endcase
      end
      if (mr) begin
         m_priv = m_ms[12:11]; m_ms[3] = m_ms[7]; m_ms[7] = 1'b1; m_ms[12:11] = 2'b00;
         m_xpc = m_mepc; m_xv = 1'b1;
      end else if (sr) begin
         m_priv = {1'b0, m_ms[8]}; m_ms[1] = m_ms[5]; m_ms[5] = 1'b1; m_ms[8] = 1'b0;
         m_xpc = m_sepc; m_xv = 1'b1;
      end
      if (ffen) m_ff = m_ff | ff;
   endfunction

   task automatic check_all(input string t);
      chk({t, ".priv"},    {62'd0, priv_o}, {62'd0, m_priv});
      chk({t, ".mstatus"}, mstatus_o, m_ms | 64'h6000);
      chk({t, ".fcsr"},    {56'd0, fcsr_o}, {56'd0, m_frm, m_ff});
      chk({t, ".mepc"},    mepc_o, m_mepc);
      chk({t, ".sepc"},    sepc_o, m_sepc);
      chk({t, ".xv"},      {63'd0, xret_valid_o}, {63'd0, m_xv});
      chk({t, ".xpc"},     xret_pc_o, m_xpc);
      chk({t, ".cf"},      {63'd0, conflict_o}, {63'd0, m_cf});
   endtask

   // drive one commit, step past the edge, then compare against the model
   task automatic commit(input string t, input logic v, input logic [63:0] d, input logic [11:0] idx,
                         input logic en, input logic mr, input logic sr,
                         input logic [4:0] ff, input logic ffen);
      cif.commit_valid_i = v;    cif.commit_csrdata_i = d;  cif.commit_csrindex_i = idx;
      cif.commit_csren_i = en;   cif.commit_mret_i = mr;    cif.commit_sret_i = sr;
      cif.commit_fflag_i = ff;   cif.commit_fflagen_i = ffen;
      @(posedge clk_i);
      #1;
      m_step(v, d, idx, en, mr, sr, ff, ffen);
      check_all(t);
   endtask

   task automatic idle(input string t);
      commit(t, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   logic [11:0] idx_tab [8] = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h100, 12'h341, 12'h141, 12'h7C0};

   initial begin
      m_reset();
      cif.commit_valid_i = 1'b0; cif.commit_csrdata_i = '0; cif.commit_csrindex_i = '0;
      cif.commit_csren_i = 1'b0; cif.commit_mret_i = 1'b0;  cif.commit_sret_i = 1'b0;
      cif.commit_fflag_i = '0;   cif.commit_fflagen_i = 1'b0;
      #12 arst_ni = 1'b1;
      @(posedge clk_i); #1;

      // T1 reset state
      chk("t1.priv", {62'd0, priv_o}, 64'd3);
      chk("t1.mstatus", mstatus_o, 64'h7800);
      chk("t1.fcsr", {56'd0, fcsr_o}, 64'd0);
      chk("t1.xv", {63'd0, xret_valid_o}, 64'd0);

      // T2 fflag accrual and same-cycle write base
      commit("t2a", 1, '0, '0, 0, 0, 0, 5'h01, 1);
      commit("t2b", 1, '0, '0, 0, 0, 0, 5'h04, 1);
      chk("t2.acc", {59'd0, fcsr_o[4:0]}, 64'h05);
      commit("t2c", 1, '0, 12'h001, 1, 0, 0, 5'h02, 1);
      chk("t2.wr_acc", {59'd0, fcsr_o[4:0]}, 64'h02);

      // T3 mret to S
      commit("t3a", 1, 64'h8000_1003, 12'h341, 1, 0, 0, '0, 0);
      commit("t3b", 1, 64'h0880, 12'h300, 1, 0, 0, '0, 0);
      commit("t3c", 1, '0, '0, 0, 1, 0, '0, 0);
      chk("t3.xv", {63'd0, xret_valid_o}, 64'd1);
      chk("t3.xpc", xret_pc_o, 64'h8000_1000);
      chk("t3.priv", {62'd0, priv_o}, 64'd1);
      chk("t3.mstatus", mstatus_o, 64'h6088);

      // T4 sret to U, one-cycle pulse
      commit("t4a", 1, 64'h0020, 12'h100, 1, 0, 0, '0, 0);
      commit("t4b", 1, 64'h2000, 12'h141, 1, 0, 0, '0, 0);
      commit("t4c", 1, '0, '0, 0, 0, 1, '0, 0);
      chk("t4.priv", {62'd0, priv_o}, 64'd0);
      chk("t4.sie", {63'd0, mstatus_o[1]}, 64'd1);
      chk("t4.xpc", xret_pc_o, 64'h2000);
      idle("t4d");
      chk("t4.pulse", {63'd0, xret_valid_o}, 64'd0);

      // T5 conflicts, back-to-back xret
      commit("t5a", 1, 64'h1888, 12'h300, 1, 0, 0, '0, 0);
      commit("t5b", 1, '0, '0, 0, 1, 1, '0, 0);
      chk("t5.cf", {63'd0, conflict_o}, 64'd1);
      chk("t5.priv", {62'd0, priv_o}, 64'd3);
      commit("t5c", 1, '0, 12'h300, 1, 1, 0, 5'h10, 1);
      chk("t5.notzero", {63'd0, mstatus_o[7]}, 64'd1);
      chk("t5.b2b_priv", {62'd0, priv_o}, 64'd0);
      idle("t5d");
      chk("t5.cf_drop", {63'd0, conflict_o}, 64'd0);

      // T6 valid gating, then async reset while a pulse is high
      commit("t6a", 0, 64'hDEAD_BEEF, 12'h341, 1, 0, 0, 5'h1F, 1);
      commit("t6b", 1, '0, '0, 0, 1, 0, '0, 0);
      #2 arst_ni = 1'b0;
      #1;
      m_reset();
      check_all("t6.arst");
      #3 arst_ni = 1'b1;
      idle("t6c");

      // random commits
      for (int i = 0; i < 400; i++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) d[12:11] = 2'b10;
         commit("rnd", $urandom_range(0, 9) != 0, d, idx_tab[$urandom_range(0, 7)],
                $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                5'($urandom), $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
